mips_imem_loader: RTL and testbench

Instruction encoder and loader for the single-cycle MIPS core. It accepts decoded instruction descriptors over a valid/ready stream, packs each into a 32-bit MIPS word using the opcode map that the main control decoder consumes (R-type, lw, sw, beq, j), and writes the words sequentially into instruction memory. It sits between the testbench or boot source and the instruction memory write port, ahead of the core's fetch and decode path.

---
 rtl/mips_isa_pkg.sv | 33 +++
 rtl/mips_instr_pack.sv | 31 +++
 rtl/mips_imem_loader.sv | 140 ++++++++++++++
 tb/tb_mips_imem_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared ISA constants for the single-cycle MIPS core: opcodes, field widths and the
// descriptor kind encoding used by the instruction loader and the main control decoder.
package mips_isa_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;
    localparam int unsigned KIND_W   = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    // Codes 5..7 are reserved and treated as illegal descriptors.
    typedef enum logic [KIND_W-1:0] {
        KindRtype = 3'd0,
        KindLw    = 3'd1,
        KindSw    = 3'd2,
        KindBeq   = 3'd3,
        KindJ     = 3'd4
    } instrKind_t;

    function automatic logic isLegalKind(input logic [KIND_W-1:0] kind);
        return kind <= KindJ;
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: turns a decoded instruction descriptor into a 32-bit MIPS word
// and flags whether the descriptor kind is one the core can execute.
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [KIND_W-1:0]   kind,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    imm,
    input  logic [TARGET_W-1:0] target,
    output logic [INSTR_W-1:0]  word,
    output logic                legal
);

    always_comb begin
        word  = '0;
        legal = isLegalKind(kind);
        case (kind)
            KindRtype: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KindLw:    word = {OP_LW, rs, rt, imm};
            KindSw:    word = {OP_SW, rs, rt, imm};
            KindBeq:   word = {OP_BEQ, rs, rt, imm};
            KindJ:     word = {OP_J, target};
            default:   word = '0;
        endcase
    end

endmodule

// File: rtl/mips_imem_loader.sv
// Session-based instruction loader: accepts descriptors on a valid/ready stream, encodes
// them and writes the words sequentially into instruction memory starting at BASE_ADDR.
module mips_imem_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KIND_W-1:0]   in_kind,
    input  logic [REG_W-1:0]    in_rs,
    input  logic [REG_W-1:0]    in_rt,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [SHAMT_W-1:0]  in_shamt,
    input  logic [FUNCT_W-1:0]  in_funct,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [TARGET_W-1:0] in_target,
    input  logic                in_last,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone,
        StErr
    } loaderState_t;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

    loaderState_t state, stateNext;

    logic [INSTR_W-1:0] packedWord;
    logic               packedLegal;
    logic               accept;
    logic               doWrite;
    logic [ADDR_W:0]    countQ;
    logic [ADDR_W:0]    countInc;
    logic [ADDR_W-1:0]  writeAddr;
    logic               memWeQ;
    logic [ADDR_W-1:0]  memAddrQ;
    logic [INSTR_W-1:0] memWdataQ;

    mips_instr_pack u_pack (
        .kind   (in_kind),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .word   (packedWord),
        .legal  (packedLegal)
    );

    assign accept    = in_valid && (state == StLoad);
    assign doWrite   = accept && packedLegal;
    assign countInc  = countQ + CountOne;
    // The low bits of count give the offset; wrap past the top of memory is intentional.
    assign writeAddr = BaseAddr + countQ[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            StIdle, StDone, StErr: begin
                if (start) begin
                    stateNext = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (!packedLegal) begin
                        stateNext = StErr;
                    end else if (in_last) begin
                        stateNext = StDone;
                    end else if (countInc[ADDR_W]) begin
                        // Memory is full and the source still has more to send.
                        stateNext = StErr;
                    end
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            StLoad:  in_ready = 1'b1;
            StDone:  done     = 1'b1;
            StErr:   err      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            countQ    <= '0;
        end else begin
            memWeQ <= doWrite;
            if (doWrite) begin
                memAddrQ  <= writeAddr;
                memWdataQ <= packedWord;
                countQ    <= countInc;
            end else if (start && (state != StLoad)) begin
                countQ <= '0;
            end
        end
    end

    assign mem_we    = memWeQ;
    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;
    assign count     = countQ;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Scoreboard bench for mips_imem_loader: three instances (8-bit, 2-bit, 2-bit with base 3)
// share the descriptor stream; each has its own start and expected-write queue.
module tb_mips_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  startV;
    logic        inValid;
    logic [2:0]  inKind;
    logic [4:0]  inRs, inRt, inRd, inShamt;
    logic [5:0]  inFunct;
    logic [15:0] inImm;
    logic [25:0] inTarget;
    logic        inLast;

    logic        readyA, weA, doneA, errA;
    logic [7:0]  addrA;
    logic [31:0] wdataA;
    logic [8:0]  countA;

    logic        readyB, weB, doneB, errB;
    logic [1:0]  addrB;
    logic [31:0] wdataB;
    logic [2:0]  countB;

    logic        readyC, weC, doneC, errC;
    logic [1:0]  addrC;
    logic [31:0] wdataC;
    logic [2:0]  countC;

    int nAsserts = 0;
    int nFails   = 0;

    logic [39:0] qA[$];
    logic [39:0] qB[$];
    logic [39:0] qC[$];
    logic [39:0] eA, eB, eC;

    always #5 clk = ~clk;

    mips_imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dutA (
        .clk(clk), .rst(rst), .start(startV[0]), .in_valid(inValid), .in_ready(readyA),
        .in_kind(inKind), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
        .in_funct(inFunct), .in_imm(inImm), .in_target(inTarget), .in_last(inLast),
        .mem_we(weA), .mem_addr(addrA), .mem_wdata(wdataA), .count(countA),
        .done(doneA), .err(errA)
    );

    mips_imem_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dutB (
        .clk(clk), .rst(rst), .start(startV[1]), .in_valid(inValid), .in_ready(readyB),
        .in_kind(inKind), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
        .in_funct(inFunct), .in_imm(inImm), .in_target(inTarget), .in_last(inLast),
        .mem_we(weB), .mem_addr(addrB), .mem_wdata(wdataB), .count(countB),
        .done(doneB), .err(errB)
    );

    mips_imem_loader #(.ADDR_W(2), .BASE_ADDR(3)) u_dutC (
        .clk(clk), .rst(rst), .start(startV[2]), .in_valid(inValid), .in_ready(readyC),
        .in_kind(inKind), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
        .in_funct(inFunct), .in_imm(inImm), .in_target(inTarget), .in_last(inLast),
        .mem_we(weC), .mem_addr(addrC), .mem_wdata(wdataC), .count(countC),
        .done(doneC), .err(errC)
    );

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Writes are checked against the queues on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (weA === 1'b1) begin
            if (qA.size() == 0) begin
                checkEq("spurious_weA", 64'd1, 64'd0);
            end else begin
                eA = qA.pop_front();
                checkEq("addrA", {56'd0, addrA}, {56'd0, eA[39:32]});
                checkEq("wdataA", {32'd0, wdataA}, {32'd0, eA[31:0]});
            end
        end
        if (weB === 1'b1) begin
            if (qB.size() == 0) begin
                checkEq("spurious_weB", 64'd1, 64'd0);
            end else begin
                eB = qB.pop_front();
                checkEq("addrB", {62'd0, addrB}, {56'd0, eB[39:32]});
                checkEq("wdataB", {32'd0, wdataB}, {32'd0, eB[31:0]});
            end
        end
        if (weC === 1'b1) begin
            if (qC.size() == 0) begin
                checkEq("spurious_weC", 64'd1, 64'd0);
            end else begin
                eC = qC.pop_front();
                checkEq("addrC", {62'd0, addrC}, {56'd0, eC[39:32]});
                checkEq("wdataC", {32'd0, wdataC}, {32'd0, eC[31:0]});
            end
        end
    end

    function automatic logic [31:0] lwWord(input logic [4:0] rt, input logic [15:0] imm);
        return {6'b100011, 5'd0, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBeat(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                           input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        inKind   = k;
        inRs     = rs;
        inRt     = rt;
        inRd     = rd;
        inShamt  = sh;
        inFunct  = fn;
        inImm    = imm;
        inTarget = tgt;
        inLast   = last;
        inValid  = 1'b1;
    endtask

    task automatic beat(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        setBeat(k, rs, rt, rd, sh, fn, imm, tgt, last);
        tick();
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic doStart(input int which);
        startV[which] = 1'b1;
        tick();
        startV = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        startV = '0;
        inValid = 1'b0;
        setBeat(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        inValid = 1'b0;
        repeat (3) tick();
        checkEq("rst_ready", {63'd0, readyA}, 64'd0);
        checkEq("rst_we", {63'd0, weA}, 64'd0);
        checkEq("rst_addr", {56'd0, addrA}, 64'd0);
        checkEq("rst_wdata", {32'd0, wdataA}, 64'd0);
        checkEq("rst_count", {55'd0, countA}, 64'd0);
        checkEq("rst_done", {63'd0, doneA}, 64'd0);
        checkEq("rst_err", {63'd0, errA}, 64'd0);
        rst = 1'b0;
        tick();

        // Single R-type with last
        doStart(0);
        checkEq("t1_ready", {63'd0, readyA}, 64'd1);
        qA.push_back({8'd0, 32'h00221820});
        beat(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b1);
        checkEq("t1_done", {63'd0, doneA}, 64'd1);
        checkEq("t1_count", {55'd0, countA}, 64'd1);
        checkEq("t1_ready_low", {63'd0, readyA}, 64'd0);
        tick();
        checkEq("t1_done_hold", {63'd0, doneA}, 64'd1);

        // Back-to-back lw, sw, beq, j
        doStart(0);
        checkEq("t2_count0", {55'd0, countA}, 64'd0);
        checkEq("t2_done_clr", {63'd0, doneA}, 64'd0);
        qA.push_back({8'd0, 32'h8C080004});
        qA.push_back({8'd1, 32'hAC080008});
        qA.push_back({8'd2, 32'h1022FFFF});
        qA.push_back({8'd3, 32'h08000010});
        beat(3'd1, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 26'h3FFFFFF, 1'b0);
        beat(3'd2, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0);
        beat(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
        beat(3'd4, 5'd7, 5'd7, 5'd7, 5'd7, 6'd7, 16'hAAAA, 26'h0000010, 1'b1);
        checkEq("t2_count", {55'd0, countA}, 64'd4);
        checkEq("t2_done", {63'd0, doneA}, 64'd1);
        tick();
        checkEq("t2_drain", 64'(qA.size()), 64'd0);

        // Illegal kind as the second beat
        doStart(0);
        qA.push_back({8'd0, 32'h00853080});
        beat(3'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'd0, 26'd0, 1'b0);
        beat(3'd5, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0);
        checkEq("t3_err", {63'd0, errA}, 64'd1);
        checkEq("t3_done", {63'd0, doneA}, 64'd0);
        checkEq("t3_ready", {63'd0, readyA}, 64'd0);
        checkEq("t3_count", {55'd0, countA}, 64'd1);
        tick();
        checkEq("t3_drain", 64'(qA.size()), 64'd0);
        doStart(0);
        checkEq("t3_err_clr", {63'd0, errA}, 64'd0);
        checkEq("t3_count_clr", {55'd0, countA}, 64'd0);
        checkEq("t3_ready2", {63'd0, readyA}, 64'd1);

        // Gaps in valid and start during LOAD
        qA.push_back({8'd0, 32'h8C691234});
        beat(3'd1, 5'd3, 5'd9, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
        tick();
        tick();
        startV[0] = 1'b1;
        tick();
        startV = '0;
        checkEq("t4_count_keep", {55'd0, countA}, 64'd1);
        checkEq("t4_ready_keep", {63'd0, readyA}, 64'd1);
        qA.push_back({8'd1, 32'h0BFFFFFF});
        beat(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF, 1'b1);
        checkEq("t4_count", {55'd0, countA}, 64'd2);
        checkEq("t4_done", {63'd0, doneA}, 64'd1);

        // Illegal kind with last set still errors
        doStart(0);
        beat(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
        checkEq("t5_err", {63'd0, errA}, 64'd1);
        checkEq("t5_done", {63'd0, doneA}, 64'd0);
        checkEq("t5_count", {55'd0, countA}, 64'd0);

        // Reset in the cycle after an acceptance, with another beat presented
        doStart(0);
        qA.push_back({8'd0, 32'hAC43FFFC});
        beat(3'd2, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b0);
        setBeat(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
        rst = 1'b1;
        startV[0] = 1'b1;
        tick();
        inValid = 1'b0;
        rst = 1'b0;
        startV = '0;
        checkEq("t6_we", {63'd0, weA}, 64'd0);
        checkEq("t6_ready", {63'd0, readyA}, 64'd0);
        checkEq("t6_addr", {56'd0, addrA}, 64'd0);
        checkEq("t6_wdata", {32'd0, wdataA}, 64'd0);
        checkEq("t6_count", {55'd0, countA}, 64'd0);
        checkEq("t6_done_err", {62'd0, doneA, errA}, 64'd0);
        tick();
        checkEq("t6_drain", 64'(qA.size()), 64'd0);

        // Overflow on a 4-word memory
        doStart(1);
        for (int i = 0; i < 4; i++) begin
            qB.push_back({8'(i), lwWord(5'(i), 16'(i + 16))});
            beat(3'd1, 5'd0, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i + 16), 26'd0, 1'b0);
        end
        checkEq("t7_err", {63'd0, errB}, 64'd1);
        checkEq("t7_done", {63'd0, doneB}, 64'd0);
        checkEq("t7_count", {61'd0, countB}, 64'd4);
        checkEq("t7_ready", {63'd0, readyB}, 64'd0);
        beat(3'd1, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0009, 26'd0, 1'b0);
        checkEq("t7_count_5th", {61'd0, countB}, 64'd4);
        tick();
        checkEq("t7_drain", 64'(qB.size()), 64'd0);

        doStart(1);
        for (int i = 0; i < 4; i++) begin
            qB.push_back({8'(i), lwWord(5'(i + 4), 16'(i))});
            beat(3'd1, 5'd0, 5'(i + 4), 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 1'(i == 3));
        end
        checkEq("t8_done", {63'd0, doneB}, 64'd1);
        checkEq("t8_err", {63'd0, errB}, 64'd0);
        checkEq("t8_count", {61'd0, countB}, 64'd4);

        // Address wrap with BASE_ADDR=3
        doStart(2);
        qC.push_back({8'd3, 32'h8C010001});
        qC.push_back({8'd0, 32'h8C020002});
        qC.push_back({8'd1, 32'h8C030003});
        for (int i = 1; i <= 3; i++) begin
            beat(3'd1, 5'd0, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 1'(i == 3));
        end
        checkEq("t9_done", {63'd0, doneC}, 64'd1);
        checkEq("t9_count", {61'd0, countC}, 64'd3);
        tick();

        checkEq("final_qA", 64'(qA.size()), 64'd0);
        checkEq("final_qB", 64'(qB.size()), 64'd0);
        checkEq("final_qC", 64'(qC.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
